// File: rtl/eth_idelay_pkg.sv
// +----------------------------------------------------------------------------+
// | eth_idelay_pkg: shared types for the RGMII IDELAYE2 tap loader.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package eth_idelay_pkg;

    localparam int idelay_tap_width_gp = 5;

    typedef enum logic [2:0] {
        WAIT_RDY = 3'd0,
        LOAD     = 3'd1,
        SETTLE   = 3'd2,
        VERIFY   = 3'd3,
        IDLE     = 3'd4,
        ERROR    = 3'd5
    } idelay_state_e;

endpackage

`default_nettype wire

// File: rtl/bsg_sync_sync.sv
// +----------------------------------------------------------------------------+
// | bsg_sync_sync: two-flop synchronizer into the oclk domain.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bsg_sync_sync #(
    parameter int width_p = 1
) (
    input  logic               oclk_i,
    input  logic               oclk_reset_i,
    input  logic [width_p-1:0] iclk_data_i,
    output logic [width_p-1:0] oclk_data_o
);

    logic [width_p-1:0] r_meta;
    logic [width_p-1:0] r_sync;

    always_ff @(posedge oclk_i or posedge oclk_reset_i) begin
        if (oclk_reset_i) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= iclk_data_i;
            r_sync <= r_meta;
        end
    end

    assign oclk_data_o = r_sync;

endmodule

`default_nettype wire

// File: rtl/rgmii_idelay_tap_loader.sv
// +----------------------------------------------------------------------------+
// | rgmii_idelay_tap_loader: loads and verifies IDELAYE2 taps on all RGMII RX  |
// | lanes once IDELAYCTRL RDY is stable, then accepts retune requests.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rgmii_idelay_tap_loader
    import eth_idelay_pkg::*;
#(
    parameter int                     lanes_p         = 5,
    parameter int                     tap_width_p     = idelay_tap_width_gp,
    parameter logic [tap_width_p-1:0] init_tap_p      = '0,
    parameter int                     rdy_stable_p    = 16,
    parameter int                     settle_cycles_p = 4,
    parameter int                     max_retries_p   = 3
) (
    input  logic                           clk_i,
    input  logic                           reset_r_i,
    input  logic                           idelay_rdy_i,
    input  logic [tap_width_p-1:0]         tap_i,
    input  logic                           tap_v_i,
    output logic                           tap_ready_o,
    output logic                           idelay_ld_o,
    output logic [tap_width_p-1:0]         idelay_cntvaluein_o,
    input  logic [lanes_p*tap_width_p-1:0] idelay_cntvalueout_i,
    output logic [tap_width_p-1:0]         tap_r_o,
    output logic                           ready_o,
    output logic                           error_o
);

    localparam int c_stable_w = $clog2(rdy_stable_p + 1);
    localparam int c_settle_w = $clog2(settle_cycles_p + 1);
    localparam int c_retry_w  = $clog2(max_retries_p + 1);

    localparam logic [c_stable_w-1:0] c_stable_max  = c_stable_w'(rdy_stable_p);
    localparam logic [c_stable_w-1:0] c_stable_last = c_stable_w'(rdy_stable_p - 1);
    localparam logic [c_settle_w-1:0] c_settle_max  = c_settle_w'(settle_cycles_p);
    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(settle_cycles_p - 1);
    localparam logic [c_retry_w-1:0]  c_retry_max   = c_retry_w'(max_retries_p);

    idelay_state_e          r_state;
    idelay_state_e          w_state_next;
    logic [tap_width_p-1:0] r_tap;
    logic [c_stable_w-1:0]  r_stable_cnt;
    logic [c_settle_w-1:0]  r_settle_cnt;
    logic [c_retry_w-1:0]   r_retry_cnt;
    logic                   w_rdy_s;
    logic                   w_accept;
    logic [lanes_p-1:0]     w_lane_ok;
    logic                   w_all_ok;

    bsg_sync_sync #(
        .width_p (1)
    ) u_rdy_sync (
        .oclk_i       (clk_i),
        .oclk_reset_i (reset_r_i),
        .iclk_data_i  (idelay_rdy_i),
        .oclk_data_o  (w_rdy_s)
    );

    for (genvar k = 0; k < lanes_p; k++) begin : g_lane
        assign w_lane_ok[k] = (idelay_cntvalueout_i[k*tap_width_p +: tap_width_p] == r_tap);
    end
    assign w_all_ok = &w_lane_ok;

    assign tap_ready_o         = ((r_state == IDLE) || (r_state == ERROR)) && w_rdy_s;
    assign w_accept            = tap_v_i && tap_ready_o;
    assign idelay_ld_o         = (r_state == LOAD);
    assign idelay_cntvaluein_o = r_tap;
    assign tap_r_o             = r_tap;
    assign ready_o             = (r_state == IDLE);
    assign error_o             = (r_state == ERROR);

    always_ff @(posedge clk_i or posedge reset_r_i) begin
        if (reset_r_i) begin
            r_state      <= WAIT_RDY;
            r_tap        <= init_tap_p;
            r_stable_cnt <= '0;
            r_settle_cnt <= '0;
            r_retry_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_tap <= tap_i;
            end
            // Both counters saturate so oversized parameters can never wrap.
            if ((r_state == WAIT_RDY) && w_rdy_s) begin
                if (r_stable_cnt != c_stable_max) begin
                    r_stable_cnt <= r_stable_cnt + c_stable_w'(1);
                end
            end else begin
                r_stable_cnt <= '0;
            end
            if (r_state == SETTLE) begin
                if (r_settle_cnt != c_settle_max) begin
                    r_settle_cnt <= r_settle_cnt + c_settle_w'(1);
                end
            end else begin
                r_settle_cnt <= '0;
            end
            if (w_accept || !w_rdy_s || ((r_state == VERIFY) && w_all_ok)) begin
                r_retry_cnt <= '0;
            end else if ((r_state == VERIFY) && (r_retry_cnt < c_retry_max)) begin
                r_retry_cnt <= r_retry_cnt + c_retry_w'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_RDY: if (w_rdy_s && (r_stable_cnt >= c_stable_last)) w_state_next = LOAD;
            LOAD:     w_state_next = SETTLE;
            SETTLE:   if (r_settle_cnt >= c_settle_last) w_state_next = VERIFY;
            VERIFY: begin
                if (w_all_ok) begin
                    w_state_next = IDLE;
                end else if (r_retry_cnt < c_retry_max) begin
                    w_state_next = LOAD;
                end else begin
                    w_state_next = ERROR;
                end
            end
            IDLE, ERROR: if (w_accept) w_state_next = LOAD;
            default:  w_state_next = WAIT_RDY;
        endcase
        // Losing RDY overrides everything; the tap is kept for the reload.
        if (!w_rdy_s) begin
            w_state_next = WAIT_RDY;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rgmii_idelay_tap_loader.sv
// +----------------------------------------------------------------------------+
// | tb_rgmii_idelay_tap_loader: directed bench with a schedule-based model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rgmii_idelay_tap_loader;

    localparam int LANES  = 5;
    localparam int W      = 5;
    localparam int STABLE = 16;
    localparam int S      = 4;
    localparam int MAXR   = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               rdy = 1'b0;
    logic               tap_v = 1'b0;
    logic [W-1:0]       tap_in = '0;
    logic               tap_ready, ld, ready, error;
    logic [W-1:0]       cntin, tap_r;
    logic [LANES*W-1:0] cntout;
    logic [W-1:0]       lane_val [LANES];
    bit                 bad_lane3 = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    rgmii_idelay_tap_loader #(
        .lanes_p         (LANES),
        .tap_width_p     (W),
        .init_tap_p      (5'd0),
        .rdy_stable_p    (STABLE),
        .settle_cycles_p (S),
        .max_retries_p   (MAXR)
    ) dut (
        .clk_i                (clk),
        .reset_r_i            (rst),
        .idelay_rdy_i         (rdy),
        .tap_i                (tap_in),
        .tap_v_i              (tap_v),
        .tap_ready_o          (tap_ready),
        .idelay_ld_o          (ld),
        .idelay_cntvaluein_o  (cntin),
        .idelay_cntvalueout_i (cntout),
        .tap_r_o              (tap_r),
        .ready_o              (ready),
        .error_o              (error)
    );

    // Emulated IDELAYE2 lanes; lane 3 can be made to load one tap short.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) lane_val[k] <= '0;
        end else if (ld) begin
            for (int k = 0; k < LANES; k++)
                lane_val[k] <= (k == 3 && bad_lane3) ? cntin - 5'd1 : cntin;
        end
    end

    always_comb begin
        cntout = '0;
        for (int k = 0; k < LANES; k++) cntout[k*W +: W] = lane_val[k];
    end

    // Model: tracks the cycle in which the next load is scheduled and derives
    // verify / ready / error timing from it arithmetically.
    bit           m_s1 = 0, m_rs = 0, m_wait = 1, m_ready = 0, m_error = 0;
    int           m_run = 0, m_load_at = -1, m_att = 0;
    logic [W-1:0] m_tap = '0;

    always @(posedge clk) begin
        bit rs_old;
        bit all_ok;
        cyc++;
        rs_old = m_rs;
        if (rst) begin
            m_s1 = 0; m_rs = 0; m_wait = 1; m_ready = 0; m_error = 0;
            m_run = 0; m_load_at = -1; m_att = 0; m_tap = '0;
        end else begin
            m_rs = m_s1;
            m_s1 = rdy;
            all_ok = 1;
            for (int k = 0; k < LANES; k++) if (lane_val[k] != m_tap) all_ok = 0;
            if (!rs_old) begin
                m_wait = 1; m_run = 0; m_load_at = -1; m_ready = 0; m_error = 0; m_att = 0;
            end else if (m_wait) begin
                m_run++;
                if (m_run >= STABLE) begin
                    m_wait = 0; m_run = 0; m_load_at = cyc; m_att = 0;
                end
            end else if ((m_ready || m_error) && tap_v) begin
                m_tap = tap_in; m_ready = 0; m_error = 0; m_load_at = cyc; m_att = 0;
            end else if (m_load_at >= 0 && (cyc - 1) == m_load_at + S + 1) begin
                if (all_ok) begin
                    m_ready = 1; m_load_at = -1;
                end else if (m_att < MAXR) begin
                    m_att++; m_load_at = cyc;
                end else begin
                    m_error = 1; m_load_at = -1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ld", ld, 0);
            chk("rst_ready", ready, 0);
            chk("rst_error", error, 0);
            chk("rst_tap_ready", tap_ready, 0);
            chk("rst_tap_r", tap_r, 0);
            chk("rst_cntin", cntin, 0);
        end else begin
            chk("ld", ld, (m_load_at == cyc));
            chk("ready", ready, m_ready);
            chk("error", error, m_error);
            chk("tap_ready", tap_ready, (m_ready || m_error) && m_rs);
            chk("tap_r", tap_r, m_tap);
            chk("cntin", cntin, m_tap);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = ld, 1 = ready, 2 = error
    task automatic wait_sig(input int which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if ((which == 0 && ld) || (which == 1 && ready) || (which == 2 && error)) begin
                at = cyc;
                break;
            end
            step();
        end
        if (at < 0) chk("timeout", which, 99);
    endtask

    task automatic request(input logic [W-1:0] t, output int n);
        n = cyc;
        chk("req_tap_ready", tap_ready, 1);
        tap_v  = 1'b1;
        tap_in = t;
        step();
        tap_v  = 1'b0;
    endtask

    initial begin
        int c0, at, n, r, d, nld;
        #1 rst = 1'b1;
        repeat (3) step();
        chk("t0_reset_tap_r", tap_r, 0);

        // Power-up: RDY high, first load 2+16 cycles later, ready S+2 after it.
        rst = 1'b0;
        c0  = cyc;
        rdy = 1'b1;
        wait_sig(0, 40, at);
        chk("t1_ld_latency", at - c0, 18);
        chk("t1_ld_tap", cntin, 0);
        wait_sig(1, 20, n);
        chk("t1_ready_latency", n - at, 6);

        // One-cycle RDY glitch after 10 synced cycles restarts the count.
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        c0  = cyc;
        repeat (10) step();
        rdy = 1'b0;
        step();
        rdy = 1'b1;
        wait_sig(0, 40, at);
        chk("t2_ld_latency", at - c0, 29);
        wait_sig(1, 20, n);

        // Retune to 17.
        step();
        request(5'd17, n);
        wait_sig(0, 5, at);
        chk("t3_ld_cycle", at - n, 1);
        wait_sig(1, 20, r);
        chk("t3_ready_cycle", r - n, 7);
        chk("t3_tap_r", tap_r, 17);

        // Lane 3 reads 16: initial load plus three reloads, then error.
        bad_lane3 = 1'b1;
        request(5'd17, n);
        nld = 0;
        at  = -1;
        for (int i = 0; i < 60; i++) begin
            if (ld) nld++;
            if (error) begin at = cyc; break; end
            step();
        end
        chk("t4_ld_count", nld, 4);
        chk("t4_error_cycle", at - n, 25);
        bad_lane3 = 1'b0;
        step();
        request(5'd9, n);
        chk("t4_error_cleared", error, 0);
        wait_sig(1, 20, r);
        chk("t4_ready_cycle", r - n, 7);
        chk("t4_tap_r", tap_r, 9);

        // RDY drop in IDLE with tap 17; retained tap reloaded on return.
        request(5'd17, n);
        wait_sig(1, 20, r);
        step();
        d   = cyc;
        rdy = 1'b0;
        step(); step();
        chk("t5_ready_d2", ready, 1);
        step();
        chk("t5_ready_d3", ready, 0);
        chk("t5_tap_kept", tap_r, 17);
        step(); step();
        r   = cyc;
        rdy = 1'b1;
        wait_sig(0, 40, at);
        chk("t5_reload_latency", at - r, 18);
        chk("t5_reload_tap", cntin, 17);
        wait_sig(1, 20, n);

        // Reset during LOAD.
        request(5'd5, n);
        chk("t6_in_load", ld, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_ld_async", ld, 0);
        chk("t6_tap_r", tap_r, 0);
        step(); step();
        rst = 1'b0;
        c0  = cyc;
        wait_sig(0, 40, at);
        chk("t6_ld_latency", at - c0, 18);
        chk("t6_ld_tap", cntin, 0);
        wait_sig(1, 20, n);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rgmii_idelay_tap_loader.md
# rgmii_idelay_tap_loader

- Sits directly downstream of the IDELAYCTRL reset/hold stage.
- Waits for the IDELAYCTRL `RDY` to be stable, then loads a tap value into every RGMII RX IDELAYE2 lane (VAR_LOAD mode) and reads each lane back to confirm the load.
- Raises `ready_o` once all lanes are verified.
- Afterwards accepts new tap values over a valid/ready handshake, for software or sweep-based retuning.

## Interface
Parameters:
- `lanes_p`, 5 — number of IDELAYE2 lanes (4 data + ctl).
- `tap_width_p`, 5 — IDELAYE2 tap width.
- `init_tap_p`, 5'd0 — tap loaded after reset / `RDY` rise.
- `rdy_stable_p`, 16 — consecutive synced-high `RDY` cycles required before loading.
- `settle_cycles_p`, 4 — wait cycles between `LD` pulse and readback.
- `max_retries_p`, 3 — reloads attempted after a verify mismatch before error.

Ports:
- `clk_i`  in  1  IDELAYE2 `C` clock; one clock.
- `reset_r_i`  in  1  reset; asynchronous, active-high.
- `idelay_rdy_i`  in  1  IDELAYCTRL `RDY`; asynchronous to `clk_i`.
- `tap_i`  in  tap_width_p  requested tap.
- `tap_v_i`  in  1  request valid.
- `tap_ready_o`  out  1  request accepted when `tap_v_i & tap_ready_o`.
- `idelay_ld_o`  out  1  `LD` to all lanes.
- `idelay_cntvaluein_o`  out  tap_width_p  `CNTVALUEIN`, broadcast to all lanes.
- `idelay_cntvalueout_i`  in  lanes_p*tap_width_p  per-lane `CNTVALUEOUT`; lane k at bits [k*w +: w].
- `tap_r_o`  out  tap_width_p  current target tap.
- `ready_o`  out  1  all lanes verified at `tap_r_o`.
- `error_o`  out  1  verify failed after all retries.

## Operation
- `idelay_rdy_i` passes through a 2-flop synchronizer to give `rdy_s`.
- FSM states:
  - WAIT_RDY: counts consecutive `rdy_s` cycles; the counter clears when `rdy_s`=0. When the count reaches `rdy_stable_p` → LOAD.
  - LOAD: one cycle; `idelay_ld_o`=1, `idelay_cntvaluein_o`=`tap_r_o`. → SETTLE.
  - SETTLE: counts `settle_cycles_p` cycles. → VERIFY.
  - VERIFY: one cycle; compares every lane's `CNTVALUEOUT` to `tap_r_o`.
    - All lanes match → IDLE, retry count cleared.
    - Any mismatch with retries < `max_retries_p` → retry+1, then LOAD.
    - Otherwise → ERROR.
  - IDLE: `ready_o`=1.
  - ERROR: `error_o`=1, `ready_o`=0.
- `tap_ready_o` = (IDLE or ERROR) & `rdy_s`.
- Accepting a request:
  - `tap_r_o` ← `tap_i` and retry count clears.
  - State → LOAD; `error_o` and `ready_o` clear on the next cycle.
- `rdy_s`=0 in any state other than WAIT_RDY forces WAIT_RDY next cycle.
  - `ready_o` and `error_o` clear; `tap_r_o` is retained; the stable counter clears.
  - After `RDY` returns, the retained tap is reloaded.
- `rdy_stable_p` and `settle_cycles_p` counters are sized `$clog2(param+1)` and saturate; they never wrap.

## Timing
- Reset values:
  - state WAIT_RDY.
  - `tap_r_o` = `idelay_cntvaluein_o` = `init_tap_p`.
  - `idelay_ld_o`, `ready_o`, `error_o`, `tap_ready_o` = 0.
  - All counters 0.
- All outputs decode from registers; there is no combinational path from inputs to outputs.
- Request accepted on edge N:
  - `idelay_ld_o` high for exactly cycle N+1.
  - SETTLE occupies N+2 … N+1+S, with S = `settle_cycles_p`.
  - VERIFY in N+2+S.
  - `ready_o` high from N+3+S.
  - Each retry adds S+2 cycles.
- `RDY` path: synchronizer latency is 2 cycles. LOAD occurs `rdy_stable_p` cycles after `rdy_s` first goes high with no drop in between.
- `rdy_s` falling in the same cycle as `tap_v_i`: no accept (`tap_ready_o` is already 0); the RDY drop wins.
- `reset_r_i` mid-LOAD or mid-SETTLE: `idelay_ld_o` drops asynchronously; state and tap return to reset values.
- `idelay_cntvaluein_o` is held stable from LOAD through VERIFY.

## Structure
- Package `eth_idelay_pkg`:
  - `idelay_state_e` (WAIT_RDY, LOAD, SETTLE, VERIFY, IDLE, ERROR).
  - `idelay_tap_width_gp` = 5.
- Synchronizer: `bsg_sync_sync` (width 1) instance for `idelay_rdy_i`.
- Settle and stable counters may use `bsg_counter_set_down`.
- All other logic is inline.

## Test plan
- Reset, then hold `RDY` high → `idelay_ld_o` pulses once with `cntvaluein`=0 at 2+16 cycles; with readback 0, `ready_o`=1 S+2 cycles later.
- `RDY` glitches low for 1 cycle at count 10 → counter restarts; LOAD is delayed by the full 16 cycles again.
- In IDLE, send tap 5'd17 → LD at N+1, `ready_o` at N+7 (S=4) with readback 17, `tap_r_o`=17.
- Lane 3 reads back 16 while the other lanes read 17 → 3 reloads, then `error_o`=1; a new request for 5'd9 clears `error_o` and reaches `ready_o`.
- Drop `RDY` during IDLE with tap 17 → `ready_o`=0 within 3 cycles; on `RDY` return, tap 17 is reloaded.
- Assert `reset_r_i` during LOAD → `idelay_ld_o`=0 immediately; `tap_r_o`=0 and the sequence restarts from WAIT_RDY.
